umi_splitter_buf: RTL
=====================

# umi_splitter_buf

Buffered 1:2 UMI traffic splitter and the inverse of the resp/req combiner. A single merged UMI stream is decoded per packet by command type. Responses are steered to output 0 and requests to output 1. Each output lane has its own 2-entry buffer, so one stalled lane never blocks traffic already destined for the other.

## Interface
- AW, 64, address width; carried for interface consistency, not used internally
- UW, 256, packet width in bits
- clk  input  1  clock
- nreset  input  1  reset; asynchronous, active-low
- umi_in_valid  input  1  merged input valid
- umi_in_packet  input  UW  merged input packet
- umi_in_ready  output  1  merged input ready
- umi_resp_out_valid  output  1  response lane valid (lane 0)
- umi_resp_out_packet  output  UW  response lane packet
- umi_resp_out_ready  input  1  response lane ready
- umi_req_out_valid  output  1  request lane valid (lane 1)
- umi_req_out_packet  output  UW  request lane packet
- umi_req_out_ready  input  1  request lane ready

## Operation
- Decode: sel = umi_in_packet[0]. Odd opcodes (bit 0 = 1) are requests and go to the req lane. Even opcodes, including 0x00, are responses and go to the resp lane.
- Transfer on any interface occurs when valid & ready on a rising clk edge.
- umi_in_ready = en & ~full[sel].
  - It depends combinationally on umi_in_packet[0]; it never depends on umi_in_valid.
  - en is a flop reset to 0 and set to 1 on the first clk edge after nreset deasserts.
- Each lane is a 2-entry FIFO holding a count (0..2), entries, and a 1-bit read pointer.
  - push = input transfer with sel matching the lane.
  - pop = out_valid & out_ready.
  - out_valid = (count != 0); out_packet = head entry.
- Full:
  - full = (count == 2).
  - A pop while full does not raise umi_in_ready in the same cycle; there is no ready flow-through, so in_ready is registered-path only.
- Push and pop in the same cycle leaves count unchanged; this gives 1 packet/cycle sustained per lane.
- Ordering:
  - Order is preserved within each lane.
  - No ordering holds between lanes; a request may exit before an earlier response or vice versa.
- Packets are never dropped, duplicated or modified; the output bit pattern equals the input bit pattern.
- Output valid is never retracted before its transfer. Packet is held stable while valid & ~ready.

## Timing
- Reset values: umi_in_ready 0; both out_valid 0; both out_packet all-zero; counts 0; pointers 0.
- Latency: 1 cycle. A packet accepted at edge N shows on its lane's out_valid/out_packet after edge N, so the earliest output transfer is at edge N+1.
- Empty lane: a push at edge N makes out_valid 1 after N; no bypass path exists.
- Full lane (count 2): umi_in_ready = 0 for packets addressed to that lane. Packets addressed to the other lane are still accepted if that lane is not full.
- Wrap-around: the read/write pointers are 1-bit and toggle. Back-to-back push/pop over many cycles must not corrupt order.
- Reset mid-operation: asynchronous assertion clears all buffered packets immediately and forces every valid to 0 and umi_in_ready to 0. After release, umi_in_ready stays 0 for one edge (the en flop).

## Structure
- A shared umi package holds the opcode constants (UMI_REQ_READ 0x01, UMI_REQ_WRITE 0x03, UMI_RESP_READ 0x02, UMI_RESP_WRITE 0x04) and the is-request bit position (0).
- Sub-module umi_splitter_lane: 2-entry synchronous FIFO with valid/ready ports and a full flag, parameter UW. The top level instantiates it twice, plus the decode logic and the en flop.
- Target size: about 150-200 RTL lines total.

## Test plan
- Reset: hold nreset low 5 cycles with umi_in_valid = 1 -> umi_in_ready = 0 and all out_valid = 0. After release, in_ready = 1 from the second edge.
- Steering: drive packets with opcode 0x03, 0x04, 0x01, 0x02, 0x00; both lanes ready -> req lane gets 0x03, 0x01 in order; resp lane gets 0x04, 0x02, 0x00 in order. Each arrives 1 cycle after acceptance.
- Lane stall isolation: hold umi_req_out_ready = 0 and send 3 requests followed by 2 responses -> the first 2 requests are accepted and the third stalls with in_ready = 0. Swap the stalled request for the 2 responses (sel changes) -> both responses are accepted and delivered. Releasing req ready then drains the requests in order.
- Full throughput: 100 consecutive requests with ready = 1 -> 100 transfers in 101 cycles, count never exceeds 1, and order matches.
- Random backpressure: 1000 mixed packets, 50% random ready on each output -> per-lane scoreboard exact, no drops or duplicates, and outputs stable while valid & ~ready.
- Async reset with both lanes full (count 2) -> outputs clear within the reset assertion. No stale packet appears after release.

Source files
------------

// File: rtl/umi_splitter_buf_pkg.sv
// Shared UMI definitions for the buffered 1:2 splitter: opcode constants,
// the request-flag bit position and the lane selector type.
package umi_splitter_buf_pkg;

  localparam logic [7:0] UMI_REQ_READ   = 8'h01;
  localparam logic [7:0] UMI_REQ_WRITE  = 8'h03;
  localparam logic [7:0] UMI_RESP_READ  = 8'h02;
  localparam logic [7:0] UMI_RESP_WRITE = 8'h04;

  // Odd opcodes are requests; everything else, including 0x00, is a response.
  localparam int UMI_REQ_BIT = 0;

  typedef enum logic {
    LANE_RESP = 1'b0,
    LANE_REQ  = 1'b1
  } lane_e;

endpackage

// File: rtl/umi_splitter_buf_if.sv
// Merged input stream plus the response and request output lanes.
// master drives the input and the output readies; slave is the splitter.
interface umi_splitter_buf_if #(
  parameter int UW = 256
);

  logic          umi_in_valid;
  logic [UW-1:0] umi_in_packet;
  logic          umi_in_ready;

  logic          umi_resp_out_valid;
  logic [UW-1:0] umi_resp_out_packet;
  logic          umi_resp_out_ready;

  logic          umi_req_out_valid;
  logic [UW-1:0] umi_req_out_packet;
  logic          umi_req_out_ready;

  modport master (
    output umi_in_valid, umi_in_packet, umi_resp_out_ready, umi_req_out_ready,
    input  umi_in_ready, umi_resp_out_valid, umi_resp_out_packet,
           umi_req_out_valid, umi_req_out_packet
  );

  modport slave (
    input  umi_in_valid, umi_in_packet, umi_resp_out_ready, umi_req_out_ready,
    output umi_in_ready, umi_resp_out_valid, umi_resp_out_packet,
           umi_req_out_valid, umi_req_out_packet
  );

endinterface

// File: rtl/umi_splitter_lane.sv
// Two-entry synchronous FIFO for one splitter lane. The caller never pushes
// while o_full is set, so no overflow guard is needed here.
module umi_splitter_lane #(
  parameter int UW = 256
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_push,
  input  logic [UW-1:0] i_packet,
  output logic          o_full,
  output logic          o_valid,
  output logic [UW-1:0] o_packet,
  input  logic          i_ready
);

  logic [UW-1:0] r_mem [2];
  logic [1:0]    r_count;
  logic          r_rd_ptr;

  logic w_pop;
  logic w_wr_ptr;

  assign w_pop    = o_valid & i_ready;
  // Write slot sits one past the head when a single entry is held.
  assign w_wr_ptr = r_rd_ptr ^ r_count[0];

  assign o_full   = (r_count == 2'd2);
  assign o_valid  = (r_count != 2'd0);
  assign o_packet = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      // NOTE: storage is reset because the idle output packet must read as all-zero.
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[w_wr_ptr] <= i_packet;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/umi_splitter_buf.sv
// Buffered 1:2 UMI splitter: responses go to lane 0, requests to lane 1,
// each through its own 2-entry FIFO so a stalled lane never blocks the other.
module umi_splitter_buf
  import umi_splitter_buf_pkg::*;
#(
  parameter int AW = 64,
  parameter int UW = 256
) (
  input  logic               clk,
  input  logic               nreset,
  umi_splitter_buf_if.slave  bus
);

  if (AW < 1) begin : g_bad_aw
    $error("umi_splitter_buf: AW must be positive");
  end

  lane_e      w_sel;
  logic [1:0] w_full;
  logic       w_in_xfer;
  logic       r_en;

  assign w_sel = lane_e'(bus.umi_in_packet[UMI_REQ_BIT]);

  // Ready follows the addressed lane only; a same-cycle pop does not flow through.
  assign bus.umi_in_ready = r_en & ~w_full[w_sel];
  assign w_in_xfer        = bus.umi_in_valid & bus.umi_in_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_en <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment.
      r_en <= 1'b1;
    end
  end

  umi_splitter_lane #(.UW(UW)) u_resp_lane (
    .clk      (clk),
    .nreset   (nreset),
    .i_push   (w_in_xfer & (w_sel == LANE_RESP)),
    .i_packet (bus.umi_in_packet),
    .o_full   (w_full[LANE_RESP]),
    .o_valid  (bus.umi_resp_out_valid),
    .o_packet (bus.umi_resp_out_packet),
    .i_ready  (bus.umi_resp_out_ready)
  );

  umi_splitter_lane #(.UW(UW)) u_req_lane (
    .clk      (clk),
    .nreset   (nreset),
    .i_push   (w_in_xfer & (w_sel == LANE_REQ)),
    .i_packet (bus.umi_in_packet),
    .o_full   (w_full[LANE_REQ]),
    .o_valid  (bus.umi_req_out_valid),
    .o_packet (bus.umi_req_out_packet),
    .i_ready  (bus.umi_req_out_ready)
  );

endmodule
